// File: rtl/hwpe_stream_addrgen_realign.sv
// Address generator for the store-side realigner: walks a 2D (lines x words) transfer
// from an arbitrary byte address, emitting aligned addresses, strobes and realign flags.
module hwpe_stream_addrgen_realign #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH-1:0]   base_addr_i,
  input  logic [CNT_WIDTH-1:0]    line_length_i,
  input  logic [CNT_WIDTH-1:0]    n_lines_i,
  input  logic [ADDR_WIDTH-1:0]   line_stride_i,
  output logic [ADDR_WIDTH-1:0]   addr_o,
  output logic                    addr_valid_o,
  input  logic                    addr_ready_i,
  output logic [DATA_WIDTH/8-1:0] strb_o,
  output logic                    realign_o,
  output logic                    first_o,
  output logic                    last_o,
  output logic                    last_packet_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int unsigned NB  = DATA_WIDTH / 8;
  localparam int unsigned OFS = $clog2(NB);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(NB - 1);
  localparam logic [CNT_WIDTH:0]    ONE_W      = 1;
  localparam logic [CNT_WIDTH-1:0]  ONE_L      = 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]            state_reg;
  logic [CNT_WIDTH:0]    word_reg;
  logic [CNT_WIDTH-1:0]  line_reg;
  logic [CNT_WIDTH-1:0]  len_reg;
  logic [CNT_WIDTH-1:0]  n_lines_reg;
  logic [ADDR_WIDTH-1:0] line_base_reg;
  logic [ADDR_WIDTH-1:0] stride_reg;
  logic [OFS-1:0]        off_reg;
  logic                  realign_reg;

  logic [CNT_WIDTH:0]    line_beats;
  logic [CNT_WIDTH:0]    last_word;
  logic [ADDR_WIDTH-1:0] word_offset;
  logic                  run;
  logic                  handshake;
  logic                  is_first;
  logic                  is_last;
  logic                  is_last_line;
  logic [NB-1:0]         head_strb;
  logic [NB-1:0]         tail_strb;
  logic [NB-1:0]         beat_strb;

  // A misaligned line spills into one extra tail beat.
  assign line_beats   = {1'b0, len_reg} + {{CNT_WIDTH{1'b0}}, realign_reg};
  assign last_word    = line_beats - ONE_W;
  assign word_offset  = ADDR_WIDTH'(word_reg) << OFS;
  assign run          = (state_reg == RUN);
  assign handshake    = run & addr_ready_i;
  assign is_first     = (word_reg == '0);
  assign is_last      = (word_reg == last_word);
  assign is_last_line = (line_reg == n_lines_reg - ONE_L);

  for (genvar gi = 0; gi < NB; gi++) begin : gen_strb
    assign head_strb[gi] = (OFS'(gi) >= off_reg);
    assign tail_strb[gi] = (OFS'(gi) <  off_reg);
  end

  always_comb begin
    beat_strb = '1;
    if (realign_reg && is_first) begin
      beat_strb = head_strb;
    end else if (realign_reg && is_last) begin
      beat_strb = tail_strb;
    end
  end

  assign addr_o        = run ? (line_base_reg + word_offset) : '0;
  assign addr_valid_o  = run;
  assign strb_o        = run ? beat_strb : '0;
  assign realign_o     = realign_reg;
  assign first_o       = run & is_first;
  assign last_o        = run & is_last;
  assign last_packet_o = run & is_last & is_last_line;
  assign busy_o        = (state_reg != IDLE);
  assign done_o        = (state_reg == DONE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= IDLE;
      word_reg      <= '0;
      line_reg      <= '0;
      len_reg       <= '0;
      n_lines_reg   <= '0;
      line_base_reg <= '0;
      stride_reg    <= '0;
      off_reg       <= '0;
      realign_reg   <= 1'b0;
    end else if (clear_i) begin
      state_reg     <= IDLE;
      word_reg      <= '0;
      line_reg      <= '0;
      len_reg       <= '0;
      n_lines_reg   <= '0;
      line_base_reg <= '0;
      stride_reg    <= '0;
      off_reg       <= '0;
      realign_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_i) begin
            word_reg      <= '0;
            line_reg      <= '0;
            len_reg       <= line_length_i;
            n_lines_reg   <= n_lines_i;
            line_base_reg <= base_addr_i & ALIGN_MASK;
            stride_reg    <= line_stride_i & ALIGN_MASK;
            off_reg       <= base_addr_i[OFS-1:0];
            realign_reg   <= |base_addr_i[OFS-1:0];
            state_reg     <= ((line_length_i == '0) || (n_lines_i == '0)) ? DONE : RUN;
          end
        end
        RUN: begin
          if (handshake) begin
            if (is_last) begin
              word_reg      <= '0;
              line_reg      <= line_reg + ONE_L;
              line_base_reg <= line_base_reg + stride_reg;
              if (is_last_line) begin
                state_reg <= DONE;
              end
            end else begin
              word_reg <= word_reg + ONE_W;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hwpe_stream_addrgen_realign.sv
// Scoreboard bench: directed transfers push hand-computed beats, a negedge monitor
// compares every presented beat against the queue head and pops on handshake.
module tb_hwpe_stream_addrgen_realign;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic        realign;
    logic        first;
    logic        last;
    logic        last_packet;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] line_length;
  logic [15:0] n_lines;
  logic [31:0] line_stride;
  logic [31:0] addr;
  logic        addr_valid;
  logic        addr_ready;
  logic [3:0]  strb;
  logic        realign;
  logic        first;
  logic        last;
  logic        last_packet;
  logic        busy;
  logic        done;

  int    tests = 0;
  int    fails = 0;
  int    cyc   = 0;
  int    beat_idx = 0;
  beat_t exp_q[$];

  hwpe_stream_addrgen_realign dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .clear_i       (clear),
    .start_i       (start),
    .base_addr_i   (base_addr),
    .line_length_i (line_length),
    .n_lines_i     (n_lines),
    .line_stride_i (line_stride),
    .addr_o        (addr),
    .addr_valid_o  (addr_valid),
    .addr_ready_i  (addr_ready),
    .strb_o        (strb),
    .realign_o     (realign),
    .first_o       (first),
    .last_o        (last),
    .last_packet_o (last_packet),
    .busy_o        (busy),
    .done_o        (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [3:0] s, input logic r,
                      input logic f, input logic l, input logic lp);
    beat_t b;
    b.addr = a; b.strb = s; b.realign = r; b.first = f; b.last = l; b.last_packet = lp;
    exp_q.push_back(b);
  endtask

  // Monitor: every cycle a beat is shown it must equal the queue head, so held beats are
  // re-checked for stability while ready is low.
  always @(negedge clk) begin
    beat_t act;
    if (rst_n && addr_valid) begin
      act = '{addr, strb, realign, first, last, last_packet};
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_beat: got 0x%0h, expected no valid beat (cycle %0d)", act, cyc);
      end else begin
        check($sformatf("beat%0d", beat_idx), act, exp_q[0]);
        $display("[TB] cycle %0d beat%0d addr=0x%08h strb=0x%0h f=%0b l=%0b lp=%0b ready=%0b",
                 cyc, beat_idx, addr, strb, first, last, last_packet, addr_ready);
        if (addr_ready) begin
          void'(exp_q.pop_front());
          beat_idx++;
        end
      end
    end
  end

  // Returns with s = cycle index of the first cycle after start was sampled.
  task automatic do_start(input logic [31:0] b, input logic [15:0] len, input logic [15:0] nl,
                          input logic [31:0] st, output int s);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; line_length = len; n_lines = nl; line_stride = st;
    @(posedge clk); #1;
    start = 1'b0;
    s = cyc;
  endtask

  task automatic wait_done(output int d);
    d = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        d = cyc;
        break;
      end
    end
    check("busy_at_done", {63'd0, busy}, 64'd1);
  endtask

  task automatic push_case1();
    push(32'h100, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    push(32'h104, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    push(32'h108, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0);
    push(32'h140, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    push(32'h144, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    push(32'h148, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic push_case2();
    push(32'h100, 4'hE, 1'b1, 1'b1, 1'b0, 1'b0);
    push(32'h104, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
    push(32'h108, 4'h1, 1'b1, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    int s;
    int d;
    bit [5:0] pat;
    rst_n = 1'b0; clear = 1'b0; start = 1'b0; addr_ready = 1'b0;
    base_addr = '0; line_length = '0; n_lines = '0; line_stride = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_outputs",
          {addr, addr_valid, strb, realign, first, last, last_packet, busy, done}, 64'd0);

    // Aligned 2x3 transfer, ready always high
    addr_ready = 1'b1;
    push_case1();
    do_start(32'h100, 16'd3, 16'd2, 32'h40, s);
    wait_done(d);
    check("c1_done_cycle", 64'(d), 64'(s + 6));
    check("c1_drained", 64'(exp_q.size()), 64'd0);

    // Misaligned single line with tail beat
    push_case2();
    do_start(32'h101, 16'd2, 16'd1, 32'h0, s);
    wait_done(d);
    check("c2_done_cycle", 64'(d), 64'(s + 3));
    check("c2_drained", 64'(exp_q.size()), 64'd0);

    // Backpressure pattern 0,1,0,0,1,1
    pat = 6'b110010;
    addr_ready = 1'b0;
    push_case2();
    do_start(32'h101, 16'd2, 16'd1, 32'h0, s);
    for (int i = 0; i < 6; i++) begin
      addr_ready = pat[i];
      @(posedge clk); #1;
    end
    addr_ready = 1'b1;
    wait_done(d);
    check("c3_done_cycle", 64'(d), 64'(s + 6));
    check("c3_drained", 64'(exp_q.size()), 64'd0);

    // Degenerate starts: zero length, then zero lines
    do_start(32'h200, 16'd0, 16'd4, 32'h40, s);
    wait_done(d);
    check("c4a_done_cycle", 64'(d), 64'(s));
    @(negedge clk);
    check("c4a_after", {62'd0, busy, done}, 64'd0);
    do_start(32'h203, 16'd5, 16'd0, 32'h40, s);
    wait_done(d);
    check("c4b_done_cycle", 64'(d), 64'(s));
    @(negedge clk);
    check("c4b_after", {62'd0, busy, done}, 64'd0);

    // Clear after two beats of the aligned transfer
    push_case1();
    do_start(32'h100, 16'd3, 16'd2, 32'h40, s);
    @(posedge clk); #1;
    @(posedge clk); #1;
    clear = 1'b1; addr_ready = 1'b0;
    @(posedge clk); #1;
    clear = 1'b0; addr_ready = 1'b1;
    @(negedge clk);
    check("c5_after_clear", {61'd0, addr_valid, busy, done}, 64'd0);
    check("c5_beats_taken", 64'(exp_q.size()), 64'd4);
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("c5_no_done", {63'd0, done}, 64'd0);
    end
    push_case1();
    do_start(32'h100, 16'd3, 16'd2, 32'h40, s);
    wait_done(d);
    check("c5_restart_done_cycle", 64'(d), 64'(s + 6));
    check("c5_restart_drained", 64'(exp_q.size()), 64'd0);

    // Address wrap at the top of the address space
    push(32'hFFFF_FFFC, 4'hC, 1'b1, 1'b1, 1'b0, 1'b0);
    push(32'h0000_0000, 4'h3, 1'b1, 1'b0, 1'b1, 1'b1);
    do_start(32'hFFFF_FFFE, 16'd1, 16'd1, 32'h0, s);
    wait_done(d);
    check("c6_done_cycle", 64'(d), 64'(s + 2));
    check("c6_drained", 64'(exp_q.size()), 64'd0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
